// File: rtl/sirv_pmu_pkg.sv
// Shared types and defaults for the PMU write-protection sequencer.
package sirv_pmu_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_COMMIT   = 2'd2
  } pmu_state_e;

  localparam int unsigned PMU_DW      = 32;
  localparam int unsigned PMU_NREG    = 4;
  localparam int unsigned PMU_TIMEOUT = 16;
  localparam logic [31:0] PMU_KEY     = 32'h0051_F15E;

endpackage

// File: rtl/sirv_pmu_win_timer.sv
// Loadable down-counter that bounds the unlock window; saturates at zero.
module sirv_pmu_win_timer #(
  parameter int unsigned TW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero_c
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/sirv_pmu_key_ctrl.sv
// Key-gated write sequencer: one correct key write permits exactly one protected register write.
module sirv_pmu_key_ctrl
  import sirv_pmu_pkg::*;
#(
  parameter int unsigned DW      = PMU_DW,
  parameter int unsigned NREG    = PMU_NREG,
  parameter logic [DW-1:0] KEY   = DW'(PMU_KEY),
  parameter int unsigned TIMEOUT = PMU_TIMEOUT,
  localparam int unsigned IW     = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int unsigned TW     = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_dbg_mode,
  input  logic            i_key_wr_valid,
  input  logic [DW-1:0]   i_key_wr_data,
  input  logic            i_wr_req_valid,
  output logic            o_wr_req_ready,
  input  logic [IW-1:0]   i_wr_req_idx,
  input  logic [DW-1:0]   i_wr_req_data,
  output logic [NREG-1:0] o_reg_we,
  output logic [DW-1:0]   o_reg_wdata,
  output logic            o_unlocked,
  output logic            o_wr_err
);

  pmu_state_e      r_state;
  pmu_state_e      w_next;
  logic            w_req;
  logic            w_key_ok;
  logic            w_key_bad;
  logic            w_idx_ok;
  logic            w_load;
  logic            w_dec;
  logic            w_zero;
  logic            w_err;
  logic [NREG-1:0] r_reg_we;
  logic [DW-1:0]   r_reg_wdata;
  logic            r_unlocked;
  logic            r_wr_err;

  // Debug mode is deliberately not part of any equation.
  logic w_unused_dbg;
  assign w_unused_dbg = i_dbg_mode;

  assign o_wr_req_ready = (r_state != ST_COMMIT);
  assign w_req     = i_wr_req_valid && o_wr_req_ready;
  assign w_key_ok  = i_key_wr_valid && (i_key_wr_data == KEY);
  assign w_key_bad = i_key_wr_valid && (i_key_wr_data != KEY);
  assign w_idx_ok  = (32'(i_wr_req_idx) < NREG);

  sirv_pmu_win_timer #(.TW(TW)) u_win_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (TW'(TIMEOUT - 1)),
    .i_dec      (w_dec),
    .o_zero_c   (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOCKED;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, timer control and error decode.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_dec  = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        if (w_key_ok) begin
          w_next = ST_UNLOCKED;
          w_load = 1'b1;
        end
        if (w_key_bad || w_req) begin
          w_err = 1'b1;
        end
      end
      ST_UNLOCKED: begin
        if (w_req) begin
          if (w_idx_ok) begin
            w_next = ST_COMMIT;
          end else begin
            w_next = ST_LOCKED;
            w_err  = 1'b1;
          end
        end else if (w_key_ok) begin
          w_load = 1'b1;
        end else if (w_key_bad) begin
          w_next = ST_LOCKED;
          w_err  = 1'b1;
        end else if (w_zero) begin
          w_next = ST_LOCKED;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_COMMIT: begin
        w_next = ST_LOCKED;
      end
      default: begin
        w_next = ST_LOCKED;
      end
    endcase
  end

  // Write enable and data are captured on the edge that enters COMMIT, so they last exactly that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_we    <= '0;
      r_reg_wdata <= '0;
      r_unlocked  <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_reg_we    <= (w_next == ST_COMMIT) ? (NREG'(1) << i_wr_req_idx) : '0;
      r_reg_wdata <= (w_next == ST_COMMIT) ? i_wr_req_data : '0;
      r_unlocked  <= (w_next == ST_UNLOCKED);
      r_wr_err    <= w_err;
    end
  end

  assign o_reg_we    = r_reg_we;
  assign o_reg_wdata = r_reg_wdata;
  assign o_unlocked  = r_unlocked;
  assign o_wr_err    = r_wr_err;

endmodule

// File: tb/tb_sirv_pmu_key_ctrl.sv
// Directed bench for sirv_pmu_key_ctrl with a window-countdown reference model checked every cycle.
module tb_sirv_pmu_key_ctrl;

  localparam int unsigned DW      = 32;
  localparam int unsigned NREG    = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] GOOD    = 32'h0051_F15E;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            dbg_mode = 1'b0;
  logic            key_wr_valid = 1'b0;
  logic [DW-1:0]   key_wr_data = '0;
  logic            wr_req_valid = 1'b0;
  logic            wr_req_ready;
  logic [1:0]      wr_req_idx = '0;
  logic [DW-1:0]   wr_req_data = '0;
  logic [NREG-1:0] reg_we;
  logic [DW-1:0]   reg_wdata;
  logic            unlocked;
  logic            wr_err;

  int checks = 0;
  int errors = 0;

  sirv_pmu_key_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_dbg_mode     (dbg_mode),
    .i_key_wr_valid (key_wr_valid),
    .i_key_wr_data  (key_wr_data),
    .i_wr_req_valid (wr_req_valid),
    .o_wr_req_ready (wr_req_ready),
    .i_wr_req_idx   (wr_req_idx),
    .i_wr_req_data  (wr_req_data),
    .o_reg_we       (reg_we),
    .o_reg_wdata    (reg_wdata),
    .o_unlocked     (unlocked),
    .o_wr_err       (wr_err)
  );

  always #5 clk = ~clk;

  // Reference model: m_left counts unlocked cycles remaining; m_we nonzero marks the commit cycle.
  int          m_left = 0;
  logic [3:0]  m_we = '0;
  logic [31:0] m_wdata = '0;
  logic        m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  = 0;
      m_we    = '0;
      m_wdata = '0;
      m_err   = 1'b0;
    end else begin
      logic        req;
      logic [3:0]  n_we;
      logic [31:0] n_wdata;
      logic        n_err;
      req     = wr_req_valid && (m_we == 0);
      n_we    = '0;
      n_wdata = '0;
      n_err   = 1'b0;
      if (m_we != 0) begin
        m_left = 0;
      end else if (m_left == 0) begin
        if (key_wr_valid && key_wr_data == GOOD) m_left = TIMEOUT;
        if ((key_wr_valid && key_wr_data != GOOD) || req) n_err = 1'b1;
      end else if (req) begin
        m_left = 0;
        if (int'(wr_req_idx) < NREG) begin
          n_we    = 4'(1 << wr_req_idx);
          n_wdata = wr_req_data;
        end else begin
          n_err = 1'b1;
        end
      end else if (key_wr_valid) begin
        if (key_wr_data == GOOD) m_left = TIMEOUT;
        else begin
          m_left = 0;
          n_err  = 1'b1;
        end
      end else begin
        m_left = m_left - 1;
      end
      m_we    = n_we;
      m_wdata = n_wdata;
      m_err   = n_err;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_reg_we",    32'(reg_we),    32'(m_we));
    chk("model_reg_wdata", reg_wdata,      m_wdata);
    chk("model_wr_err",    32'(wr_err),    32'(m_err));
    chk("model_unlocked",  32'(unlocked),  32'(m_left > 0));
    chk("model_ready",     32'(wr_req_ready), 32'(m_we == 0));
    chk("model_onehot",    32'($countones(reg_we) <= 1), 32'(1));
  end

  // Apply one cycle of stimulus at posedge+1 and return just after the consuming edge.
  task automatic step(input logic kv, input logic [31:0] kd, input logic rv,
                      input logic [1:0] idx, input logic [31:0] d);
    key_wr_valid = kv;
    key_wr_data  = kd;
    wr_req_valid = rv;
    wr_req_idx   = idx;
    wr_req_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 2'd0, '0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #12;
    chk("reset_reg_we",   32'(reg_we),   32'h0);
    chk("reset_unlocked", 32'(unlocked), 32'h0);
    chk("reset_wr_err",   32'(wr_err),   32'h0);
    chk("reset_ready",    32'(wr_req_ready), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Unlock then write register 2
    step(1'b1, GOOD, 1'b0, 2'd0, '0);
    chk("t1_unlocked", 32'(unlocked), 32'h1);
    idle(2);
    step(1'b0, '0, 1'b1, 2'd2, 32'hA5);
    chk("t1_reg_we",    32'(reg_we),   32'h4);
    chk("t1_reg_wdata", reg_wdata,     32'hA5);
    chk("t1_unlocked",  32'(unlocked), 32'h0);
    chk("t1_ready",     32'(wr_req_ready), 32'h0);
    idle(1);
    chk("t1_we_gone",   32'(reg_we),   32'h0);

    // Locked request in debug mode is still rejected
    dbg_mode = 1'b1;
    chk("t2_ready", 32'(wr_req_ready), 32'h1);
    step(1'b0, '0, 1'b1, 2'd1, 32'h77);
    chk("t2_wr_err", 32'(wr_err), 32'h1);
    chk("t2_reg_we", 32'(reg_we), 32'h0);
    idle(1);

    // Window expires after exactly TIMEOUT idle cycles
    step(1'b1, GOOD, 1'b0, 2'd0, '0);
    idle(TIMEOUT - 1);
    chk("t3_still_open", 32'(unlocked), 32'h1);
    idle(1);
    chk("t3_closed", 32'(unlocked), 32'h0);
    step(1'b0, '0, 1'b1, 2'd0, 32'h55);
    chk("t3_wr_err", 32'(wr_err), 32'h1);
    chk("t3_reg_we", 32'(reg_we), 32'h0);
    dbg_mode = 1'b0;
    idle(1);

    // Bad keys
    step(1'b1, 32'h1234_5678, 1'b0, 2'd0, '0);
    chk("t4_bad_err",  32'(wr_err),   32'h1);
    chk("t4_bad_lock", 32'(unlocked), 32'h0);
    step(1'b1, GOOD, 1'b0, 2'd0, '0);
    chk("t4_open", 32'(unlocked), 32'h1);
    step(1'b1, 32'hDEAD_0000, 1'b0, 2'd0, '0);
    chk("t4_relock_err", 32'(wr_err),   32'h1);
    chk("t4_relock",     32'(unlocked), 32'h0);
    idle(1);

    // Back-to-back requests: second one lands in LOCKED
    step(1'b1, GOOD, 1'b0, 2'd0, '0);
    step(1'b0, '0, 1'b1, 2'd0, 32'h11);
    chk("t5_reg_we", 32'(reg_we),       32'h1);
    chk("t5_ready",  32'(wr_req_ready), 32'h0);
    step(1'b0, '0, 1'b1, 2'd1, 32'h22);
    chk("t5_no_we",  32'(reg_we), 32'h0);
    step(1'b0, '0, 1'b1, 2'd1, 32'h22);
    chk("t5_wr_err", 32'(wr_err), 32'h1);
    chk("t5_no_we2", 32'(reg_we), 32'h0);
    idle(1);

    // Same-cycle key and request: key wins when locked, request wins when unlocked
    step(1'b1, GOOD, 1'b1, 2'd1, 32'h33);
    chk("t7_err",  32'(wr_err),   32'h1);
    chk("t7_open", 32'(unlocked), 32'h1);
    step(1'b1, 32'h0BAD_0BAD, 1'b1, 2'd3, 32'h44);
    chk("t7_we",   32'(reg_we), 32'h8);
    chk("t7_noerr", 32'(wr_err), 32'h0);
    idle(1);

    // Correct key mid-window reloads the timer
    step(1'b1, GOOD, 1'b0, 2'd0, '0);
    idle(10);
    step(1'b1, GOOD, 1'b0, 2'd0, '0);
    idle(TIMEOUT - 1);
    chk("t8_reload_open", 32'(unlocked), 32'h1);
    idle(1);
    chk("t8_reload_closed", 32'(unlocked), 32'h0);

    // Reset during the commit cycle kills the pulse at once
    step(1'b1, GOOD, 1'b0, 2'd0, '0);
    step(1'b0, '0, 1'b1, 2'd3, 32'hDEAD_BEEF);
    chk("t6_we_before", 32'(reg_we), 32'h8);
    wr_req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_we_reset",       32'(reg_we),       32'h0);
    chk("t6_unlocked_reset", 32'(unlocked),     32'h0);
    chk("t6_ready_reset",    32'(wr_req_ready), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    chk("t6_we_after", 32'(reg_we), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
